// File: rtl/digit_pkg.sv
// Shared constants for the digit counter slice.
//   CNT_W      : width of one display digit
//   MOD_BCD    : decimal digit modulus
//   MOD_HEX    : hexadecimal digit modulus
//   DIV_* / DB_* : prescaler and debounce lengths for the 50 MHz board
//                  and short values for simulation
package digit_pkg;

    localparam int CNT_W     = 4;
    localparam int MOD_BCD   = 10;
    localparam int MOD_HEX   = 16;

    localparam int DIV_BOARD = 50_000_000;  // 1 Hz step at 50 MHz
    localparam int DB_BOARD  = 1_000_000;   // 20 ms button settle at 50 MHz

    localparam int DIV_SIM   = 4;
    localparam int DB_SIM    = 3;

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-FF synchronizer, debounce counter and
// rising-edge pulse. Reusable for any board button.
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   btn_in    in   raw asynchronous, bouncing button
//   btn_level out  debounced button level
//   btn_rise  out  one-cycle pulse when the debounced level goes 0->1
module button_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise
);

    // Counter only has to reach DB_CYCLES-1: the flip happens on the edge
    // that would make it DB_CYCLES.
    localparam int              DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic            r_level_d;
    logic [DB_W-1:0] r_db_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_db_cnt  <= '0;
        end else begin
            r_sync1   <= btn_in;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            if (r_sync2 == r_level) begin
                // any agreement restarts the settle window
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_level  <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    assign btn_level = r_level;
    assign btn_rise  = r_level & ~r_level_d;

endmodule

// File: rtl/digit_counter.sv
// Single 4-bit display digit. Advances once per prescaler tick (auto mode)
// or once per debounced button press (manual mode); counts up or down
// modulo MOD, supports a saturating parallel load and emits a one-cycle
// terminal-count pulse for cascading a second digit.
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   en        in   freezes prescaler, count and step acceptance when 0
//   auto_mode in   1 = prescaler ticks, 0 = button presses
//   up        in   1 = increment, 0 = decrement
//   step_btn  in   raw push-button
//   load      in   parallel load strobe (has priority over counting)
//   load_val  in   value to load, saturated to MOD-1
//   cnt       out  current digit
//   tc        out  wrap-around pulse, aligned with the wrapped cnt
module digit_counter
    import digit_pkg::*;
#(
    parameter int DIV       = DIV_BOARD,
    parameter int MOD       = MOD_HEX,
    parameter int DB_CYCLES = DB_BOARD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             auto_mode,
    input  logic             up,
    input  logic             step_btn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam int               PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOD - 1);

    logic [PRE_W-1:0] r_pre;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tc;

    logic w_tick;
    logic w_step;
    logic w_adv;
    logic w_btn_level_unused;

    function automatic logic [CNT_W-1:0] sat_load(input logic [CNT_W-1:0] v);
        if (int'(v) >= MOD) return CNT_LAST;
        return v;
    endfunction

    button_debounce #(
        .DB_CYCLES(DB_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (step_btn),
        .btn_level(w_btn_level_unused),
        .btn_rise (w_step)
    );

    assign w_tick = en & auto_mode & (r_pre == PRE_LAST);
    // A press seen while disabled or in auto mode is dropped, never queued.
    assign w_adv  = w_tick | (~auto_mode & en & w_step);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
            r_cnt <= '0;
            r_tc  <= 1'b0;
        end else begin
            if (!auto_mode) begin
                r_pre <= '0;
            end else if (en) begin
                r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
            end

            r_tc <= 1'b0;
            if (load) begin
                r_cnt <= sat_load(load_val);
            end else if (w_adv) begin
                if (up) begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        r_tc  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end else begin
                    if (r_cnt == '0) begin
                        r_cnt <= CNT_LAST;
                        r_tc  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
            end
        end
    end

    assign cnt = r_cnt;
    assign tc  = r_tc;

endmodule

// File: tb/tb_digit_counter.sv
module tb_digit_counter;
    import digit_pkg::*;

    localparam int DIV = DIV_SIM;
    localparam int DB  = DB_SIM;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             auto_mode;
    logic             up;
    logic             step_btn;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic             tc_a;
    logic             tc_b;

    int checks = 0;
    int errors = 0;

    // reference model state (shared prescaler/button, one count per modulus)
    int m_pre;
    int m_ca;
    int m_cb;
    bit m_tca;
    bit m_tcb;
    bit m_hist[16];   // m_hist[k] = step_btn sampled k+1 edges ago
    bit m_stable;
    bit m_pend;

    digit_counter #(.DIV(DIV), .MOD(MOD_BCD), .DB_CYCLES(DB)) dut_a (
        .clk(clk), .rst(rst), .en(en), .auto_mode(auto_mode), .up(up),
        .step_btn(step_btn), .load(load), .load_val(load_val),
        .cnt(cnt_a), .tc(tc_a)
    );

    digit_counter #(.DIV(DIV), .MOD(MOD_HEX), .DB_CYCLES(DB)) dut_b (
        .clk(clk), .rst(rst), .en(en), .auto_mode(auto_mode), .up(up),
        .step_btn(step_btn), .load(load), .load_val(load_val),
        .cnt(cnt_b), .tc(tc_b)
    );

    always #5 clk = ~clk;

    function automatic void model_cnt(input int modv, input bit adv, inout int c, output bit t);
        t = 1'b0;
        if (load) begin
            c = (int'(load_val) < modv) ? int'(load_val) : modv - 1;
        end else if (adv) begin
            if (up) begin
                t = (c == modv - 1);
                c = (c + 1) % modv;
            end else begin
                t = (c == 0);
                c = (c + modv - 1) % modv;
            end
        end
    endfunction

    // One rising edge: advance the model with the inputs present at the
    // edge, then wait 1 time unit so DUT outputs can be sampled.
    task automatic clk_edge();
        bit tick;
        bit adv;
        bit flip;
        @(posedge clk);
        if (rst) begin
            m_pre = 0; m_ca = 0; m_cb = 0; m_tca = 0; m_tcb = 0;
            for (int k = 0; k < 16; k++) m_hist[k] = 1'b0;
            m_stable = 1'b0;
            m_pend   = 1'b0;
        end else begin
            tick = en && auto_mode && (m_pre == DIV - 1);
            adv  = tick || (!auto_mode && en && m_pend);
            model_cnt(MOD_BCD, adv, m_ca, m_tca);
            model_cnt(MOD_HEX, adv, m_cb, m_tcb);
            if (!auto_mode) m_pre = 0;
            else if (en) m_pre = tick ? 0 : m_pre + 1;
            // a level is accepted once the synchronized input (2 edges
            // behind) has disagreed with it for DB consecutive cycles
            flip = 1'b1;
            for (int k = 1; k <= DB; k++)
                if (m_hist[k] == m_stable) flip = 1'b0;
            m_pend = flip && !m_stable;
            if (flip) m_stable = !m_stable;
            for (int k = 15; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = step_btn;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; auto_mode = 1'b1; up = 1'b1;
        step_btn = 1'b0; load = 1'b1; load_val = 4'd5;
        repeat (3) clk_edge();
        checks++;
        if (cnt_a !== 4'd0 || tc_a !== 1'b0 || cnt_b !== 4'd0 || tc_b !== 1'b0) begin
            errors++;
            $display("FAIL reset: cnt_a=%0d tc_a=%0b cnt_b=%0d tc_b=%0b, expected all 0",
                     cnt_a, tc_a, cnt_b, tc_b);
        end
    endtask

    task automatic test_auto_wrap();
        int ea;
        int eb;
        rst = 1'b0; load = 1'b0;
        for (int n = 1; n <= 44; n++) begin
            clk_edge();
            ea = (n / DIV) % MOD_BCD;
            eb = (n / DIV) % MOD_HEX;
            checks++;
            if (cnt_a !== 4'(ea) || tc_a !== (n == 40) || cnt_b !== 4'(eb) || tc_b !== 1'b0) begin
                errors++;
                $display("FAIL auto_wrap edge %0d: cnt_a=%0d tc_a=%0b cnt_b=%0d tc_b=%0b, expected %0d %0b %0d 0",
                         n, cnt_a, tc_a, cnt_b, tc_b, ea, (n == 40), eb);
            end
        end
    endtask

    task automatic test_down_load();
        int exp_seq[4];
        int idx;
        int prev;
        exp_seq = '{2, 1, 0, 15};
        up = 1'b0; load = 1'b1; load_val = 4'd3;
        clk_edge();
        load = 1'b0;
        checks++;
        if (cnt_a !== 4'd3 || cnt_b !== 4'd3 || tc_a !== 1'b0 || tc_b !== 1'b0) begin
            errors++;
            $display("FAIL load3: cnt_a=%0d cnt_b=%0d tc=%0b/%0b, expected 3 3 0/0",
                     cnt_a, cnt_b, tc_a, tc_b);
        end
        idx = 0; prev = 3;
        for (int n = 0; n < 5 * DIV && idx < 4; n++) begin
            clk_edge();
            if (cnt_b !== 4'(prev)) begin
                checks++;
                if (cnt_b !== 4'(exp_seq[idx]) || tc_b !== (idx == 3)) begin
                    errors++;
                    $display("FAIL down_seq step %0d: cnt_b=%0d tc_b=%0b, expected %0d %0b",
                             idx, cnt_b, tc_b, exp_seq[idx], (idx == 3));
                end
                prev = int'(cnt_b);
                idx++;
            end
            checks++;
            if (cnt_a !== 4'(m_ca) || tc_a !== m_tca) begin
                errors++;
                $display("FAIL down_bcd: cnt_a=%0d tc_a=%0b, expected %0d %0b", cnt_a, tc_a, m_ca, m_tca);
            end
        end
        checks++;
        if (idx != 4) begin
            errors++;
            $display("FAIL down_timeout: saw %0d decrements, expected 4", idx);
        end
        load = 1'b1; load_val = 4'hC;
        clk_edge();
        load = 1'b0;
        checks++;
        if (cnt_a !== 4'd9 || cnt_b !== 4'hC || tc_a !== 1'b0 || tc_b !== 1'b0) begin
            errors++;
            $display("FAIL load_sat: cnt_a=%0d cnt_b=%0d, expected 9 12", cnt_a, cnt_b);
        end
    endtask

    task automatic test_manual();
        int c0;
        int pat[5];
        pat = '{1, 0, 1, 1, 0};
        auto_mode = 1'b0; en = 1'b1; up = 1'b1; step_btn = 1'b0;
        repeat (10) clk_edge();
        c0 = int'(cnt_b);
        step_btn = 1'b1;
        for (int n = 1; n <= DB + 3; n++) begin
            clk_edge();
            checks++;
            if (cnt_b !== 4'((n == DB + 3) ? (c0 + 1) % 16 : c0)) begin
                errors++;
                $display("FAIL press_latency edge %0d: cnt_b=%0d, expected %0d",
                         n, cnt_b, (n == DB + 3) ? (c0 + 1) % 16 : c0);
            end
        end
        repeat (10) clk_edge();
        step_btn = 1'b0;
        repeat (12) clk_edge();
        checks++;
        if (cnt_b !== 4'((c0 + 1) % 16)) begin
            errors++;
            $display("FAIL hold_release: cnt_b=%0d, expected %0d", cnt_b, (c0 + 1) % 16);
        end
        c0 = int'(cnt_b);
        for (int i = 0; i < 5; i++) begin
            step_btn = pat[i][0];
            clk_edge();
        end
        step_btn = 1'b1;
        repeat (10) clk_edge();
        step_btn = 1'b0;
        repeat (12) clk_edge();
        checks++;
        if (cnt_b !== 4'((c0 + 1) % 16) || cnt_a !== 4'(m_ca)) begin
            errors++;
            $display("FAIL bounce: cnt_b=%0d cnt_a=%0d, expected %0d %0d",
                     cnt_b, cnt_a, (c0 + 1) % 16, m_ca);
        end
    endtask

    task automatic test_simultaneous();
        int c0;
        auto_mode = 1'b1; en = 1'b1; up = 1'b1; step_btn = 1'b0;
        for (int i = 0; i < 2 * DIV && m_pre != DIV - 1; i++) clk_edge();
        load = 1'b1; load_val = 4'd5;
        clk_edge();
        load = 1'b0;
        checks++;
        if (cnt_a !== 4'd5 || tc_a !== 1'b0 || cnt_b !== 4'd5 || tc_b !== 1'b0) begin
            errors++;
            $display("FAIL load_on_tick: cnt_a=%0d tc_a=%0b cnt_b=%0d tc_b=%0b, expected 5 0 5 0",
                     cnt_a, tc_a, cnt_b, tc_b);
        end
        for (int i = 0; i < 2 * DIV && m_pre != DIV - 1; i++) clk_edge();
        en = 1'b0;
        c0 = int'(cnt_b);
        repeat (6) clk_edge();
        checks++;
        if (cnt_b !== 4'(c0)) begin
            errors++;
            $display("FAIL en0_tick: cnt_b=%0d, expected %0d", cnt_b, c0);
        end
        // prescaler held at its last value, so the tick fires on re-enable
        en = 1'b1;
        clk_edge();
        checks++;
        if (cnt_b !== 4'((c0 + 1) % 16)) begin
            errors++;
            $display("FAIL en_resume: cnt_b=%0d, expected %0d", cnt_b, (c0 + 1) % 16);
        end
        auto_mode = 1'b0; en = 1'b0; step_btn = 1'b1;
        c0 = int'(cnt_b);
        repeat (10) clk_edge();
        step_btn = 1'b0;
        repeat (2) clk_edge();
        en = 1'b1;
        repeat (8) clk_edge();
        checks++;
        if (cnt_b !== 4'(c0)) begin
            errors++;
            $display("FAIL en0_press: cnt_b=%0d, expected %0d", cnt_b, c0);
        end
    endtask

    task automatic test_reset_mid();
        auto_mode = 1'b1; en = 1'b1; up = 1'b1; step_btn = 1'b0;
        for (int i = 0; i < 2 * DIV && m_pre != 2; i++) clk_edge();
        step_btn = 1'b1;
        repeat (3) clk_edge();
        load = 1'b1; load_val = 4'd7;
        clk_edge();
        load = 1'b0;
        checks++;
        if (cnt_b !== 4'd7 || m_pre != 2) begin
            errors++;
            $display("FAIL reset_mid_setup: cnt_b=%0d pre=%0d, expected 7 2", cnt_b, m_pre);
        end
        rst = 1'b1; step_btn = 1'b0;
        clk_edge();
        rst = 1'b0;
        checks++;
        if (cnt_a !== 4'd0 || tc_a !== 1'b0 || cnt_b !== 4'd0 || tc_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: cnt_a=%0d cnt_b=%0d tc=%0b/%0b, expected 0 0 0/0",
                     cnt_a, cnt_b, tc_a, tc_b);
        end
        for (int n = 1; n <= DIV; n++) begin
            clk_edge();
            checks++;
            if (cnt_b !== 4'((n == DIV) ? 1 : 0) || cnt_a !== 4'((n == DIV) ? 1 : 0)) begin
                errors++;
                $display("FAIL reset_first_tick edge %0d: cnt_a=%0d cnt_b=%0d, expected %0d",
                         n, cnt_a, cnt_b, (n == DIV) ? 1 : 0);
            end
        end
        auto_mode = 1'b0;
        repeat (8) clk_edge();
        checks++;
        if (cnt_b !== 4'd1) begin
            errors++;
            $display("FAIL stale_pulse: cnt_b=%0d, expected 1", cnt_b);
        end
    endtask

    task automatic test_mode_switch();
        int c0;
        auto_mode = 1'b1; en = 1'b1; up = 1'b1; step_btn = 1'b0;
        for (int i = 0; i < 2 * DIV && m_pre != 2; i++) clk_edge();
        auto_mode = 1'b0;
        repeat (5) clk_edge();
        auto_mode = 1'b1;
        c0 = int'(cnt_b);
        for (int n = 1; n <= DIV; n++) begin
            clk_edge();
            checks++;
            if (cnt_b !== 4'((n == DIV) ? (c0 + 1) % 16 : c0)) begin
                errors++;
                $display("FAIL mode_switch edge %0d: cnt_b=%0d, expected %0d",
                         n, cnt_b, (n == DIV) ? (c0 + 1) % 16 : c0);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            en  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 49) == 0) auto_mode = ~auto_mode;
            up = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) step_btn = ~step_btn;
            load = ($urandom_range(0, 19) == 0);
            load_val = 4'($urandom_range(0, 15));
            clk_edge();
            checks++;
            if (cnt_a !== 4'(m_ca) || tc_a !== m_tca || cnt_b !== 4'(m_cb) || tc_b !== m_tcb
                || cnt_a > 4'd9) begin
                errors++;
                $display("FAIL random cyc %0d: a=%0d/%0b b=%0d/%0b, expected a=%0d/%0b b=%0d/%0b",
                         n, cnt_a, tc_a, cnt_b, tc_b, m_ca, m_tca, m_cb, m_tcb);
            end
        end
        rst = 1'b0; load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_auto_wrap();
        test_down_load();
        test_manual();
        test_simultaneous();
        test_reset_mid();
        test_mode_switch();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
